// File: rtl/arbitro_1.sv
// ---------------------------------------------------------------------------
// arbitro_1 : 4-to-1 merging arbiter, transaction-layer ingress side.
//
// Pops words from four per-class first-word-fall-through FIFOs and pushes
// them, tagged with their class, into one shared downstream FIFO. Classes
// are served round-robin with at most BURST consecutive words per grant;
// downstream Almost_full stalls popping in the same cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset_L      asynchronous active-low reset
//   FIFO_empty   bit i high = input FIFO i empty
//   data_in0..3  head word of input FIFO i (valid while FIFO_empty[i]=0)
//   Almost_full  downstream FIFO almost full
//   Pop          one-hot or zero pop strobe to input FIFO i (combinational)
//   Push         push strobe to the downstream FIFO (registered)
//   data_out     word being pushed (registered, held while Push=0)
//   class_out    class index of data_out (registered, held while Push=0)
// ---------------------------------------------------------------------------
module arbitro_1 #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned BURST  = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [3:0]        FIFO_empty,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              Almost_full,
    output logic [3:0]        Pop,
    output logic              Push,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        class_out
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StServe = 2'd1,
        StHold  = 2'd2
    } state_e;

    localparam logic [3:0] BurstLast = 4'(BURST - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [1:0]        r_grant;
    logic [1:0]        w_grant_next;
    logic [3:0]        r_burst_cnt;
    logic [3:0]        w_burst_cnt_next;
    logic              r_push;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_class;

    logic              w_search_hit;
    logic [1:0]        w_search_idx;
    logic [1:0]        w_cand;
    logic              w_pop_en;
    logic [DATA_W-1:0] w_data_sel;

    // Next non-empty class in the order grant+1, grant+2, grant+3, grant.
    // The current grant comes last so it is only re-picked when it is the
    // sole non-empty source.
    always_comb begin
        w_search_hit = 1'b0;
        w_search_idx = r_grant;
        w_cand       = r_grant;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_grant + 2'(k);
            if (!w_search_hit && !FIFO_empty[w_cand]) begin
                w_search_hit = 1'b1;
                w_search_idx = w_cand;
            end
        end
    end

    // Pop only the granted class, only when it has data and downstream has room.
    always_comb begin
        w_pop_en = (r_state == StServe) && !FIFO_empty[r_grant] && !Almost_full;
        Pop      = w_pop_en ? (4'b0001 << r_grant) : 4'b0000;
    end

    always_comb begin
        unique case (r_grant)
            2'd0:    w_data_sel = data_in0;
            2'd1:    w_data_sel = data_in1;
            2'd2:    w_data_sel = data_in2;
            default: w_data_sel = data_in3;
        endcase
    end

    always_comb begin
        w_state_next     = r_state;
        w_grant_next     = r_grant;
        w_burst_cnt_next = r_burst_cnt;
        case (r_state)
            StIdle: begin
                if (!Almost_full && w_search_hit) begin
                    w_grant_next     = w_search_idx;
                    w_burst_cnt_next = 4'd0;
                    w_state_next     = StServe;
                end
            end
            StServe: begin
                if (Almost_full) begin
                    // Grant and burst count survive the stall.
                    w_state_next = StHold;
                end else if (w_pop_en) begin
                    if (r_burst_cnt == BurstLast) begin
                        // Burst exhausted: rotate in the same cycle, no bubble.
                        // The granted FIFO is non-empty here, so the search hits.
                        w_burst_cnt_next = 4'd0;
                        w_grant_next     = w_search_idx;
                    end else begin
                        w_burst_cnt_next = r_burst_cnt + 4'd1;
                    end
                end else begin
                    // Granted FIFO ran dry: move on, or park if nobody has data.
                    w_burst_cnt_next = 4'd0;
                    if (w_search_hit) begin
                        w_grant_next = w_search_idx;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            StHold: begin
                if (!Almost_full) begin
                    w_state_next = StServe;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= StIdle;
            r_grant     <= 2'd3;
            r_burst_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_burst_cnt <= w_burst_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_push  <= 1'b0;
            r_data  <= '0;
            r_class <= 2'd0;
        end else begin
            r_push <= w_pop_en;
            if (w_pop_en) begin
                r_data  <= w_data_sel;
                r_class <= r_grant;
            end
        end
    end

    assign Push      = r_push;
    assign data_out  = r_data;
    assign class_out = r_class;

endmodule

// File: tb/tb_arbitro_1.sv
// ---------------------------------------------------------------------------
// tb_arbitro_1 : self-checking bench for arbitro_1.
// Four queue-backed FIFO models feed the DUT; every expected pushed word
// ({class, data}) is queued when stimulus is loaded and compared in order
// whenever the DUT asserts Push.
// ---------------------------------------------------------------------------
module tb_arbitro_1;

    localparam int unsigned DATA_W = 6;
    localparam int unsigned BURST  = 4;

    logic              clk         = 1'b0;
    logic              reset_L     = 1'b0;
    logic [3:0]        FIFO_empty  = 4'hF;
    logic [DATA_W-1:0] data_in0    = '0;
    logic [DATA_W-1:0] data_in1    = '0;
    logic [DATA_W-1:0] data_in2    = '0;
    logic [DATA_W-1:0] data_in3    = '0;
    logic              Almost_full = 1'b0;
    logic [3:0]        Pop;
    logic              Push;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        class_out;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] q2[$];
    logic [DATA_W-1:0] q3[$];
    logic [7:0]        expq[$];
    logic [7:0]        mon_exp;
    logic [3:0]        pend = 4'h0;

    int n_checks = 0;
    int n_pass   = 0;

    arbitro_1 #(
        .DATA_W(DATA_W),
        .BURST (BURST)
    ) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .FIFO_empty (FIFO_empty),
        .data_in0   (data_in0),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_in3   (data_in3),
        .Almost_full(Almost_full),
        .Pop        (Pop),
        .Push       (Push),
        .data_out   (data_out),
        .class_out  (class_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic load(input int c, input logic [DATA_W-1:0] d);
        case (c)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            2:       q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic expect_word(input int c, input logic [DATA_W-1:0] d);
        expq.push_back({2'(c), d});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset_L = 1'b0;
        Almost_full = 1'b0;
        @(negedge clk);
        #1 reset_L = 1'b1;
    endtask

    task automatic wait_pop(input int budget);
        int n = 0;
        while (Pop == 4'h0 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((expq.size() != 0 || Push || Pop != 4'h0 || !(&FIFO_empty)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(expq.size()), 32'd0);
    endtask

    // Pop as seen just before the active edge decides what the FIFO models lose.
    always @(negedge clk) begin
        #4;
        pend = Pop;
    end

    // FIFO models: apply the pop, then present the new heads.
    always @(posedge clk) begin
        #1;
        if (pend[0] && q0.size() > 0) void'(q0.pop_front());
        if (pend[1] && q1.size() > 0) void'(q1.pop_front());
        if (pend[2] && q2.size() > 0) void'(q2.pop_front());
        if (pend[3] && q3.size() > 0) void'(q3.pop_front());
        FIFO_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
        data_in0   = (q0.size() > 0) ? q0[0] : '0;
        data_in1   = (q1.size() > 0) ? q1[0] : '0;
        data_in2   = (q2.size() > 0) ? q2[0] : '0;
        data_in3   = (q3.size() > 0) ? q3[0] : '0;
    end

    // Invariants and scoreboard.
    always @(negedge clk) begin
        check("pop_onehot0", 32'($onehot0(Pop)), 32'd1);
        check("pop_on_empty", 32'(Pop & FIFO_empty), 32'd0);
        if (Push) begin
            if (expq.size() == 0) begin
                check("push_extra", 32'(Push), 32'd0);
            end else begin
                mon_exp = expq.pop_front();
                check("push_word", 32'({class_out, data_out}), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int                run_len;
        logic [3:0]        pat[6];

        // Reset, then idle with every source empty.
        @(negedge clk);
        check("rst_outputs", 32'({Pop, Push, class_out, data_out}), 32'd0);
        #1 reset_L = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_quiet", 32'({Pop, Push, class_out, data_out}), 32'd0);
        end

        // Single source: class 2 with three words.
        do_reset();
        @(negedge clk);
        #1;
        load(2, 6'h11); load(2, 6'h12); load(2, 6'h13);
        expect_word(2, 6'h11); expect_word(2, 6'h12); expect_word(2, 6'h13);
        wait_pop(20);
        for (int i = 0; i < 3; i++) begin
            check("single_pop", 32'(Pop), 32'h4);
            @(negedge clk);
        end
        check("single_pop_end", 32'(Pop), 32'h0);
        check("single_push_last", 32'(Push), 32'd1);
        @(negedge clk);
        check("single_push_done", 32'(Push), 32'd0);
        drain("single_drain");

        // Round-robin bursts: all four classes hold eight words.
        do_reset();
        @(negedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 8; k++) begin
                load(c, 6'(c * 8 + k));
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                for (int k = 0; k < 4; k++) begin
                    expect_word(c, 6'(c * 8 + r * 4 + k));
                end
            end
        end
        run_len = 0;
        while (!Push && run_len < 30) begin
            @(negedge clk);
            run_len++;
        end
        run_len = 0;
        while (Push && run_len < 40) begin
            run_len++;
            @(negedge clk);
        end
        check("rr_push_run", 32'(run_len), 32'd32);
        drain("rr_drain");

        // Backpressure mid-burst on class 1.
        do_reset();
        @(negedge clk);
        #1;
        for (int k = 0; k < 6; k++) load(1, 6'(8'h20 + k));
        load(2, 6'h30); load(2, 6'h31);
        for (int k = 0; k < 4; k++) expect_word(1, 6'(8'h20 + k));
        expect_word(2, 6'h30); expect_word(2, 6'h31);
        expect_word(1, 6'h24); expect_word(1, 6'h25);
        wait_pop(20);
        @(negedge clk);
        @(negedge clk);
        check("bp_before", 32'(Pop), 32'h2);
        check("bp_inflight", 32'(Push), 32'd1);
        #1 Almost_full = 1'b1;
        #1;
        check("bp_gate", 32'(Pop), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", 32'({Pop, Push}), 32'd0);
        end
        #1 Almost_full = 1'b0;
        @(negedge clk);
        check("bp_resume", 32'(Pop), 32'h2);
        @(negedge clk);
        check("bp_resume2", 32'(Pop), 32'h2);
        @(negedge clk);
        check("bp_rotate", 32'(Pop), 32'h4);
        drain("bp_drain");

        // Skip empty classes: only 0 and 3 have data.
        do_reset();
        @(negedge clk);
        #1;
        for (int k = 1; k <= 5; k++) load(0, 6'(k));
        load(3, 6'h3A); load(3, 6'h3B);
        for (int k = 1; k <= 4; k++) expect_word(0, 6'(k));
        expect_word(3, 6'h3A); expect_word(3, 6'h3B); expect_word(0, 6'h05);
        pat[0] = 4'h1; pat[1] = 4'h1; pat[2] = 4'h1;
        pat[3] = 4'h1; pat[4] = 4'h8; pat[5] = 4'h8;
        wait_pop(20);
        for (int i = 0; i < 6; i++) begin
            check("skip_pattern", 32'(Pop), 32'(pat[i]));
            @(negedge clk);
        end
        drain("skip_drain");

        // Asynchronous reset in the middle of a class-3 burst.
        do_reset();
        @(negedge clk);
        #1;
        load(1, 6'h15); load(1, 6'h16);
        for (int k = 0; k < 6; k++) load(3, 6'(8'h2A + k));
        expect_word(1, 6'h15); expect_word(1, 6'h16); expect_word(3, 6'h2A);
        run_len = 0;
        while (Pop != 4'h8 && run_len < 40) begin
            @(negedge clk);
            run_len++;
        end
        check("ar_grant3", 32'(Pop), 32'h8);
        #1;
        load(0, 6'h07); load(0, 6'h08);
        @(negedge clk);
        check("ar_second", 32'(Pop), 32'h8);
        @(posedge clk);
        #2 reset_L = 1'b0;
        #1;
        check("ar_clear", 32'({Pop, Push, class_out, data_out}), 32'd0);
        @(negedge clk);
        #1 reset_L = 1'b1;
        expect_word(0, 6'h07); expect_word(0, 6'h08);
        for (int k = 2; k < 6; k++) expect_word(3, 6'(8'h2A + k));
        wait_pop(20);
        check("ar_restart", 32'(Pop), 32'h1);
        drain("ar_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
